// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide FSM encodings and datapath widths.
package cpu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int MD_CNT_W   = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_MULT   = 2'd1,
        MD_DIV    = 2'd2,
        MD_FINISH = 2'd3
    } md_state_e;
endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Sign handling for signed division: operand magnitudes on entry and
// quotient/remainder negation on completion.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_neg_i,
    input  logic             r_neg_i,
    output logic [WIDTH-1:0] a_abs_o,
    output logic [WIDTH-1:0] b_abs_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o
);
    // Magnitudes are unsigned, so |-2^(W-1)| = 2^(W-1) is representable.
    assign a_abs_o = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
    assign b_abs_o = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
    assign q_o     = q_neg_i ? (~q_i + 1'b1) : q_i;
    assign r_o     = r_neg_i ? (~r_i + 1'b1) : r_i;
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit sharing one
// 2*WIDTH+1 shift register and one WIDTH+1 adder/subtractor.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [2*WIDTH:0] acc_q;
    logic [WIDTH-1:0] opb_q;
    logic             is_div_q, q_neg_q, r_neg_q, dz_pend_q;
    logic             busy_q, done_q, div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   add_x, add_y, add_s;
    logic             add_sub;
    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i     (a_in),
        .b_i     (b_in),
        .q_i     (acc_q[WIDTH-1:0]),
        .r_i     (acc_q[2*WIDTH-1:WIDTH]),
        .q_neg_i (q_neg_q),
        .r_neg_i (r_neg_q),
        .a_abs_o (a_abs),
        .b_abs_o (b_abs),
        .q_o     (q_fix),
        .r_o     (r_fix)
    );

    // MULT: P +/- M on Booth pair {Q0,q-1}, sign-extended so min*min cannot overflow.
    // DIV: trial subtract of divisor from the left-shifted partial remainder.
    always_comb begin
        add_x   = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        add_y   = (acc_q[1] ^ acc_q[0]) ? {opb_q[WIDTH-1], opb_q} : '0;
        add_sub = acc_q[1] & ~acc_q[0];
        if (state_q == MD_DIV) begin
            add_x   = {1'b0, acc_q[2*WIDTH-2:WIDTH-1]};
            add_y   = {1'b0, opb_q};
            add_sub = 1'b1;
        end
        add_s = add_sub ? (add_x - add_y) : (add_x + add_y);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (mult_start) begin
                        acc_q     <= {{WIDTH{1'b0}}, b_in, 1'b0};
                        opb_q     <= a_in;
                        is_div_q  <= 1'b0;
                        dz_pend_q <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= MD_MULT;
                    end else if (div_start) begin
                        is_div_q <= 1'b1;
                        q_neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        r_neg_q  <= a_in[WIDTH-1];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (b_in == '0) begin
                            dz_pend_q <= 1'b1;
                            state_q   <= MD_FINISH;
                        end else begin
                            dz_pend_q <= 1'b0;
                            acc_q     <= {{(WIDTH+1){1'b0}}, a_abs};
                            opb_q     <= b_abs;
                            state_q   <= MD_DIV;
                        end
                    end
                end
                MD_MULT: begin
                    acc_q <= {add_s, acc_q[WIDTH:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= MD_FINISH;
                end
                MD_DIV: begin
                    // Negative trial result means restore: keep the shifted remainder, quotient bit 0.
                    if (add_s[WIDTH])
                        acc_q <= {1'b0, acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_q <= {1'b0, add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= MD_FINISH;
                end
                MD_FINISH: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    div_zero_q <= dz_pend_q;
                    if (!dz_pend_q) begin
                        if (is_div_q) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= acc_q[2*WIDTH:WIDTH+1];
                            lo_q <= acc_q[WIDTH:1];
                        end
                    end
                    cnt_q   <= '0;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results queued at start, checked on done.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_hi = '0, last_lo = '0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi_out", 64'(hi_out), 64'(e.hi));
                chk("lo_out", 64'(lo_out), 64'(e.lo));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
            end
        end
    end

    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint pa, pb, p;
        int     sa, sb_;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        e.dz = 1'b0;
        if (is_mult) begin
            p    = pa * pb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
            e.hi = last_hi;
            e.lo = last_lo;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
        end else begin
            sa   = $signed(a);
            sb_  = $signed(b);
            e.lo = 32'(sa / sb_);
            e.hi = 32'(sa % sb_);
        end
        return e;
    endfunction

    // Drives one operation; optional collision pulse at edge inj_at, optional reset at edge rst_at.
    task automatic run_op(input bit is_mult, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input int inj_at, input int rst_at);
        exp_t e;
        int   edge_n, lat;
        e = model(is_mult, a, b);
        sb.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        lat = (!is_mult && b == 32'd0) ? 1 : 33;
        @(negedge clk);
        a_in = a; b_in = b;
        mult_start = is_mult; div_start = !is_mult | both;
        @(posedge clk);
        edge_n = 0;
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0;
        while (!done && edge_n < 100) begin
            chk("busy_during_op", 64'(busy), 64'd1);
            if (edge_n == rst_at) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_hi", 64'(hi_out), 64'd0);
                chk("rst_lo", 64'(lo_out), 64'd0);
                sb.delete();
                last_hi = '0; last_lo = '0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (edge_n == inj_at) begin
                div_start = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'd3;
            end else begin
                div_start = 1'b0;
            end
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            div_start = 1'b0;
        end
        chk("latency", 64'(edge_n), 64'(lat));
        chk("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(div_zero), 64'd0);
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, -1, -1);
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(1'b0, 1'b0, 32'h0000_0451, 32'h0000_0020, -1, -1);
        run_op(1'b0, 1'b0, 32'd5, 32'd0, -1, -1);
        run_op(1'b1, 1'b1, 32'd1234, 32'hFFFF_FFC8, 10, -1);
        run_op(1'b1, 1'b0, 32'h1234_5678, 32'h0BAD_F00D, -1, 15);
        chk("sb_flushed", 64'(sb.size()), 64'd0);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, -1, -1);
        for (int i = 0; i < 8; i++)
            run_op(i[0], 1'b0, $urandom, (i == 6) ? 32'd0 : $urandom, -1, -1);
        run_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1);
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'd7, -1, -1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
